// File: rtl/imul_operand_packer.sv
// -----------------------------------------------------------------------------
// imul_operand_packer
//
// Feeds requests to the iterative multiplier. Operand words arrive one at a
// time on a val/rdy stream, A first and then B. Each pair is packed into one
// request {A, B}, which matches the multiplier's istream_msg layout. Completed
// requests wait in a small FIFO and leave on a val/rdy output stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_val     upstream word valid
//   in_rdy     packer can accept a word this cycle
//   in_msg     operand word (two's complement, passed through unchanged)
//   out_val    FIFO head holds a valid packed request
//   out_rdy    multiplier accepts the head request
//   out_msg    packed request {A, B}
//   count      number of requests currently held in the FIFO
//   a_pending  operand A captured, waiting for B
// -----------------------------------------------------------------------------
module imul_operand_packer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [WORD_W-1:0]            in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [2*WORD_W-1:0]          out_msg,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         a_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t                  state;
  logic [WORD_W-1:0]       a_reg;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [2*WORD_W-1:0]     storage [DEPTH];

  logic word_xfer;
  logic push;
  logic pop;

  // in_rdy is derived only from registered state and count. A pop on this
  // edge frees a slot that becomes visible one cycle later, so out_rdy never
  // reaches in_rdy combinationally.
  assign in_rdy    = (state == WAIT_A) || (count != FULL_COUNT);
  assign a_pending = (state == WAIT_B);
  assign out_val   = (count != '0);
  assign out_msg   = storage[rd_ptr];

  assign word_xfer = in_val && in_rdy;
  assign push      = word_xfer && (state == WAIT_B);
  assign pop       = out_val && out_rdy;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT_A;
      a_reg  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        WAIT_A: if (word_xfer) begin
          a_reg <= in_msg;
          state <= WAIT_B;
        end
        WAIT_B: if (word_xfer) begin
          state <= WAIT_A;
        end
        default: state <= WAIT_A;
      endcase

      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is reset as well, so out_msg reads zero after
  // reset. Skipping this would save reset routing but leave out_msg undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (push) begin
      storage[wr_ptr] <= {a_reg, in_msg};
    end
  end

endmodule

// File: tb/tb_imul_operand_packer.sv
module tb_imul_operand_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [63:0] out_msg;
  logic [2:0]  count;
  logic        a_pending;

  int checks = 0;
  int errors = 0;

  // Scoreboard state for the wrap-around phase.
  int   exp_i;
  logic tog;
  logic acc;

  imul_operand_packer #(.DEPTH(4), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .count     (count),
    .a_pending (a_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it has been accepted.
  task automatic send_word(input logic [31:0] w);
    int n;
    in_val = 1'b1;
    in_msg = w;
    n = 0;
    while (!in_rdy && n < 20) begin
      tick();
      n++;
    end
    check("send_no_timeout", {63'd0, in_rdy}, 64'd1);
    tick();
    in_val = 1'b0;
    in_msg = 32'hDEAD_BEEF;
  endtask

  // One cycle of the wrap-around phase: out_rdy toggles every cycle and
  // every pop is compared with the next expected pair.
  task automatic cycle_wrap();
    out_rdy = tog;
    tog     = ~tog;
    if (out_val && out_rdy) begin
      check("wrap_order", out_msg, {32'(exp_i), 32'(100 + exp_i)});
      exp_i++;
    end
    acc = in_val && in_rdy;
    tick();
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;
    exp_i   = 0;
    tog     = 1'b1;
    acc     = 1'b0;

    // Reset state
    tick();
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_val",   64'(out_val),   64'd0);
    check("rst_out_msg",   out_msg,        64'd0);
    check("rst_in_rdy",    64'(in_rdy),    64'd1);
    check("rst_a_pending", 64'(a_pending), 64'd0);
    rst = 1'b0;
    tick();

    // 1. Single pair with out_rdy held high
    out_rdy = 1'b1;
    send_word(32'h0000_0003);
    check("t1_a_pending", 64'(a_pending), 64'd1);
    check("t1_no_out",    64'(out_val),   64'd0);
    send_word(32'h0000_0005);
    check("t1_out_val",   64'(out_val),   64'd1);
    check("t1_out_msg",   out_msg,        64'h0000_0003_0000_0005);
    check("t1_count1",    64'(count),     64'd1);
    tick();
    check("t1_count0",    64'(count),     64'd0);
    check("t1_empty",     64'(out_val),   64'd0);

    // 2. Signed words pass through bit-exact
    send_word(32'hFFFF_FFF9);
    send_word(32'h0000_0006);
    check("t2_out_msg",   out_msg,        64'hFFFF_FFF9_0000_0006);
    tick();
    check("t2_count0",    64'(count),     64'd0);
    out_rdy = 1'b0;

    // 3. Fill and backpressure
    for (int w = 1; w <= 8; w++) send_word(32'(w));
    check("t3_full",      64'(count),     64'd4);
    check("t3_head",      out_msg,        64'h0000_0001_0000_0002);
    send_word(32'd9);
    check("t3_a9_pend",   64'(a_pending), 64'd1);
    check("t3_rdy_low",   64'(in_rdy),    64'd0);
    in_val = 1'b1;
    in_msg = 32'd10;
    tick();
    check("t3_hold_cnt",  64'(count),     64'd4);
    check("t3_hold_pend", 64'(a_pending), 64'd1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("t3_pop_cnt",   64'(count),     64'd3);
    check("t3_new_head",  out_msg,        64'h0000_0003_0000_0004);
    check("t3_rdy_back",  64'(in_rdy),    64'd1);
    tick();
    in_val = 1'b0;
    check("t3_w10_cnt",   64'(count),     64'd4);
    check("t3_w10_pend",  64'(a_pending), 64'd0);
    check("t3_head_hold", out_msg,        64'h0000_0003_0000_0004);

    // Drain two entries to reach count=2
    out_rdy = 1'b1;
    tick();
    check("t3_drain1",    out_msg,        64'h0000_0005_0000_0006);
    tick();
    out_rdy = 1'b0;
    check("t3_drain2",    out_msg,        64'h0000_0007_0000_0008);
    check("t3_cnt2",      64'(count),     64'd2);

    // 4. Simultaneous push and pop at count=2
    send_word(32'h0000_00A1);
    in_val  = 1'b1;
    in_msg  = 32'h0000_00B1;
    out_rdy = 1'b1;
    tick();
    in_val  = 1'b0;
    check("t4_cnt_same",  64'(count),     64'd2);
    check("t4_head_adv",  out_msg,        64'h0000_0009_0000_000A);
    tick();
    check("t4_tail",      out_msg,        64'h0000_00A1_0000_00B1);
    tick();
    out_rdy = 1'b0;
    check("t4_drained",   64'(count),     64'd0);

    // 5. Wrap-around with toggling out_rdy
    for (int w = 0; w < 20; w++) begin
      in_val = 1'b1;
      in_msg = (w % 2 == 0) ? 32'(w / 2) : 32'(100 + w / 2);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 40) begin
        cycle_wrap();
        n++;
      end
      in_val = 1'b0;
      check("t5_word_accepted", {63'd0, acc}, 64'd1);
    end
    n = 0;
    while (exp_i < 10 && n < 40) begin
      cycle_wrap();
      n++;
    end
    out_rdy = 1'b0;
    check("t5_all_popped", 64'(exp_i),    64'd10);
    check("t5_empty",      64'(count),    64'd0);

    // 6. Asynchronous reset mid-pair
    send_word(32'h0000_0055);
    send_word(32'h0000_0066);
    send_word(32'h0000_0011);
    check("t6_pre_pend",   64'(a_pending), 64'd1);
    check("t6_pre_val",    64'(out_val),   64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_val",  64'(out_val),   64'd0);
    check("t6_rst_cnt",    64'(count),     64'd0);
    check("t6_rst_pend",   64'(a_pending), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_word(32'h0000_0022);
    send_word(32'h0000_0033);
    check("t6_out_msg",    out_msg,        64'h0000_0022_0000_0033);
    check("t6_count",      64'(count),     64'd1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("t6_empty",      64'(count),     64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
